// File: rtl/mux4_rr_pkg.sv
// Shared types and the round-robin winner function for the 4-channel mux scan controller.
package mux4_rr_pkg;

   localparam int NUM_CH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_e;

   // Scans from last_grant+1 upward and wraps, so the previous winner is checked last.
   function automatic logic [1:0] next_grant(input logic [NUM_CH-1:0] req,
                                             input logic [1:0]        last_grant);
      logic [1:0] idx;
      logic [1:0] win;
      win = last_grant;
      for (int i = NUM_CH; i >= 1; i--) begin
         idx = last_grant + 2'(i);
         if (req[idx]) win = idx;
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: winner among four requests, searching after the last grant.
module rr_pick4
   import mux4_rr_pkg::*;
(
   input  logic [NUM_CH-1:0] req_i,
   input  logic [1:0]        last_grant_i,
   output logic [1:0]        grant_o,
   output logic              any_req_o
);

   assign grant_o   = next_grant(req_i, last_grant_i);
   assign any_req_o = |req_i;

endmodule

// File: rtl/mux4_rr_scan.sv
// Round-robin scan controller: drives the 4:1 mux select, waits for settling, samples mux_z
// and presents the bit with its channel on a valid/ready port, pulsing ack to the served channel.
//
//   state  | meaning
//   IDLE   | waiting for any request; sel holds its last value
//   SETTLE | sel driven, counting down settle time before sampling mux_z
//   HOLD   | sample presented on out_*, waiting for out_ready
module mux4_rr_scan
   import mux4_rr_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   output logic [1:0]        sel,
   input  logic              mux_z,
   output logic [NUM_CH-1:0] ack,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_data,
   output logic [1:0]        out_chan
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        sel_q, sel_d;
   logic [1:0]        last_grant_q, last_grant_d;
   logic [NUM_CH-1:0] ack_q, ack_d;
   logic              out_valid_q, out_valid_d;
   logic              out_data_q, out_data_d;
   logic [1:0]        out_chan_q, out_chan_d;

   logic [1:0]        grant;
   logic              any_req;

   rr_pick4 u_pick (
      .req_i        (req),
      .last_grant_i (last_grant_q),
      .grant_o      (grant),
      .any_req_o    (any_req)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sel_q        <= '0;
         last_grant_q <= 2'd3;
         ack_q        <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= 1'b0;
         out_chan_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
         ack_q        <= ack_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_chan_q   <= out_chan_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sel_d        = sel_q;
      last_grant_d = last_grant_q;
      ack_d        = '0;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_chan_d   = out_chan_q;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               sel_d   = grant;
               cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               out_data_d   = mux_z;
               out_chan_d   = sel_q;
               out_valid_d  = 1'b1;
               ack_d        = NUM_CH'(1) << sel_q;
               last_grant_d = sel_q;
               state_d      = HOLD;
            end
         end
         HOLD: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign sel       = sel_q;
   assign ack       = ack_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;

endmodule
